// File: rtl/popcount_seq.sv
// Sequential population counter: sums CHUNK bits of a WIDTH-bit word per clock under a start/busy/done handshake.
// Optional POPCOUNT_THRESH_EN adds a captured threshold input and a registered at_least flag.
module popcount_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             count_zeros,
`ifdef POPCOUNT_THRESH_EN
    input  logic [CW-1:0]    thresh,
    output logic             at_least,
`endif
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    count
);

    localparam int N  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("popcount_seq: CHUNK must be >= 1 and divide WIDTH exactly");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] operand_q;
    logic [CW-1:0]    acc_q;
    logic [CW-1:0]    acc_d;
    logic [IW-1:0]    idx_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    count_q;
    logic [CHUNK-1:0] chunk_bits;
    logic             last_chunk;
`ifdef POPCOUNT_THRESH_EN
    logic [CW-1:0]    thresh_q;
    logic             at_least_q;
`endif

    function automatic logic [CW-1:0] pop_chunk(input logic [CHUNK-1:0] bits);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK; i++) begin
            n = n + CW'(bits[i]);
        end
        return n;
    endfunction

    // The accumulator cannot overflow: its width already holds WIDTH.
    always_comb begin
        chunk_bits = CHUNK'(operand_q >> (int'(idx_q) * CHUNK));
        acc_d      = acc_q + pop_chunk(chunk_bits);
        last_chunk = (idx_q == LAST_IDX);
    end

    // NOTE: every register, the operand included, is cleared by reset so an aborted operation leaves no trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            operand_q  <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
`ifdef POPCOUNT_THRESH_EN
            thresh_q   <= '0;
            at_least_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        operand_q <= count_zeros ? ~data_in : data_in;
                        acc_q     <= '0;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_COUNT;
`ifdef POPCOUNT_THRESH_EN
                        thresh_q  <= thresh;
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_COUNT: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + IW'(1);
                    if (last_chunk) begin
                        count_q    <= acc_d;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_DONE;
`ifdef POPCOUNT_THRESH_EN
                        at_least_q <= (acc_d >= thresh_q);
`endif
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
`ifdef POPCOUNT_THRESH_EN
    assign at_least = at_least_q;
`endif

endmodule

// File: tb/tb_popcount_seq.sv
// Scoreboard bench for popcount_seq: an 8-bit/2-bit-chunk instance and a 3-bit/1-bit-chunk instance.
// Threshold checks are compiled in when POPCOUNT_THRESH_EN is defined.
module tb_popcount_seq;

    typedef struct {
        int unsigned cnt;
        int          acc;
        bit          al;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cz8, start3, cz3;
    logic [7:0] data8;
    logic [2:0] data3;
    logic       busy8, done8, busy3, done3;
    logic [3:0] count8;
    logic [1:0] count3;
`ifdef POPCOUNT_THRESH_EN
    logic [3:0] thr8;
    logic [1:0] thr3;
    logic       al8, al3;
`endif

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   last8 = 0;
    exp_t q8[$];
    exp_t q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    popcount_seq #(.WIDTH(8), .CHUNK(2)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .data_in(data8), .count_zeros(cz8),
`ifdef POPCOUNT_THRESH_EN
        .thresh(thr8), .at_least(al8),
`endif
        .busy(busy8), .done(done8), .count(count8)
    );

    popcount_seq #(.WIDTH(3), .CHUNK(1)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .data_in(data3), .count_zeros(cz3),
`ifdef POPCOUNT_THRESH_EN
        .thresh(thr3), .at_least(al3),
`endif
        .busy(busy3), .done(done3), .count(count3)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: each done pulse pops one expected result.
    always @(negedge clk) begin
        if (!rst && done8) begin
            if (q8.size() == 0) begin
                check("done8_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("count8", 32'(count8), e.cnt);
                check("latency8", cyc - e.acc, 4);
`ifdef POPCOUNT_THRESH_EN
                check("at_least8", 32'(al8), 32'(e.al));
`endif
            end
        end
        if (!rst && done3) begin
            if (q3.size() == 0) begin
                check("done3_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("count3", 32'(count3), e.cnt);
                check("latency3", cyc - e.acc, 3);
`ifdef POPCOUNT_THRESH_EN
                check("at_least3", 32'(al3), 32'(e.al));
`endif
            end
        end
    end

    task automatic push8(input logic [7:0] d, input logic cz, input int unsigned th);
        exp_t e;
        e.cnt = cz ? 8 - $countones(d) : $countones(d);
        e.acc = cyc + 1;
        e.al  = (e.cnt >= th);
        q8.push_back(e);
    endtask

    // One isolated operation; start pulses and operand changes during COUNT must be ignored.
    task automatic run8(input logic [7:0] d, input logic cz, input int unsigned th);
        int unsigned exp_cnt;
        exp_cnt = cz ? 8 - $countones(d) : $countones(d);
        data8  = d;
        cz8    = cz;
`ifdef POPCOUNT_THRESH_EN
        thr8   = 4'(th);
`endif
        start8 = 1'b1;
        push8(d, cz, th);
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("busy8", 32'(busy8), 1);
            check("no_done8", 32'(done8), 0);
            check("hold8", 32'(count8), last8);
            data8  = ~data8;
            cz8    = ~cz8;
            start8 = (i == 1);
            tick();
        end
        check("busy8_end", 32'(busy8), 0);
        check("done8_hi", 32'(done8), 1);
        tick();
        check("done8_pulse", 32'(done8), 0);
        check("busy8_idle", 32'(busy8), 0);
        last8 = int'(exp_cnt);
    endtask

    task automatic run3(input int v);
        int unsigned gold[8];
        exp_t e;
        gold = '{0, 1, 1, 2, 1, 2, 2, 3};
        data3  = 3'(v);
        start3 = 1'b1;
        e.cnt  = gold[v];
        e.acc  = cyc + 1;
        e.al   = 1'b1;
        q3.push_back(e);
        tick();
        start3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("busy3", 32'(busy3), 1);
            tick();
        end
        check("done3_hi", 32'(done3), 1);
        tick();
        check("done3_pulse", 32'(done3), 0);
    endtask

    initial begin
        logic [7:0] alt [4];
        alt = '{8'h0F, 8'h81, 8'h0F, 8'h81};
        rst = 1'b1;
        start8 = 1'b0; cz8 = 1'b0; data8 = '0;
        start3 = 1'b0; cz3 = 1'b0; data3 = '0;
`ifdef POPCOUNT_THRESH_EN
        thr8 = '0; thr3 = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy8", 32'(busy8), 0);
        check("rst_done8", 32'(done8), 0);
        check("rst_count8", 32'(count8), 0);
        check("rst_count3", 32'(count3), 0);
`ifdef POPCOUNT_THRESH_EN
        check("rst_at_least8", 32'(al8), 0);
`endif
        rst = 1'b0;
        tick();

        run8(8'h00, 1'b0, 0);
        run8(8'hFF, 1'b0, 0);
        run8(8'hA5, 1'b0, 0);
        run8(8'h01, 1'b1, 0);

        // Back-to-back with start held high; operand noise during COUNT must not leak in.
        start8 = 1'b1;
        cz8    = 1'b0;
        for (int j = 0; j < 4; j++) begin
            data8 = alt[j];
            push8(alt[j], 1'b0, 0);
            tick();
            repeat (4) begin
                data8 = 8'($urandom);
                tick();
            end
        end
        start8 = 1'b0;
        tick();
        tick();
        check("b2b_idle", 32'(busy8), 0);

        // Reset during the second COUNT cycle discards the operation.
        data8  = 8'hFF;
        start8 = 1'b1;
        push8(8'hFF, 1'b0, 0);
        tick();
        start8 = 1'b0;
        tick();
        rst = 1'b1;
        q8.delete();
        #1;
        check("midrst_busy8", 32'(busy8), 0);
        check("midrst_done8", 32'(done8), 0);
        check("midrst_count8", 32'(count8), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            check("midrst_no_done8", 32'(done8), 0);
            tick();
        end
        last8 = 0;
        run8(8'h03, 1'b0, 0);

        for (int v = 0; v < 8; v++) run3(v);

`ifdef POPCOUNT_THRESH_EN
        run8(8'h1F, 1'b0, 5);
        run8(8'h0F, 1'b0, 5);
        run8(8'h00, 1'b0, 0);
`endif

        tick();
        check("pending8", q8.size(), 0);
        check("pending3", q3.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/popcount_seq.md
Name: popcount_seq

Overview:
- Parametrised sequential population counter; successor to the 3-input one-counter gate structures.
- Counts ones (or zeros) in a WIDTH-bit word, CHUNK bits per clock, under a start/busy/done handshake.
- Sits as a reusable arithmetic unit beside the combinational counters; its WIDTH=3 configuration serves as a checked replacement for them.

Parameters:
- WIDTH, 8, input word width in bits; must be >= 1.
- CHUNK, 2, bits summed per COUNT cycle; must divide WIDTH exactly. Elaboration error otherwise.
- CW, $clog2(WIDTH+1), result width (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request; sampled on the rising edge while state is IDLE or DONE.
- data_in  input  WIDTH  operand; captured on the accepting edge.
- count_zeros  input  1  mode: 0 = count ones, 1 = count zeros; captured on the accepting edge.
- busy  output  1  high while state is COUNT.
- done  output  1  single-cycle result-valid pulse.
- count  output  CW  result register; holds its value until the next completion.

Behaviour:
- States: IDLE, COUNT, DONE. N = WIDTH/CHUNK.
- Reset (asynchronous, any time, including mid-COUNT):
  - state = IDLE; busy, done, count, accumulator, chunk index and operand register all clear to 0.
  - An in-flight operation is discarded; no done pulse is produced for it.
- Accepting edge k: state is IDLE or DONE and start=1.
  - operand <= count_zeros ? ~data_in : data_in.
  - acc <= 0; idx <= 0; state <= COUNT. busy reads 1 after edge k.
- COUNT, edges k+1 .. k+N:
  - acc <= acc + popcount(operand[idx*CHUNK +: CHUNK]); idx <= idx+1.
  - The adder is CW bits wide; no overflow is possible because max = WIDTH.
- Edge k+N, the last chunk:
  - count <= final sum; done <= 1; busy <= 0; state <= DONE.
- DONE lasts exactly one cycle; done returns to 0 at edge k+N+1.
  - With start=0 at edge k+N+1: state <= IDLE.
  - With start=1 at edge k+N+1: the new operation is accepted (back-to-back).
  - Throughput: one result per N+1 cycles.
- start while in COUNT is ignored. It is not queued. data_in and count_zeros changes during COUNT have no effect.
- count is updated only at completion edges. It is not cleared on accept.
- Latency: done high in the cycle following edge k+N, i.e. N cycles after the accepting edge.
- WIDTH=CHUNK (N=1): single COUNT cycle; all the rules above still apply.

Optional Feature:
- Macro POPCOUNT_THRESH_EN.
- When defined:
  - Adds input thresh (CW bits), captured on the accepting edge.
  - Adds output at_least (1 bit), updated together with count at the completion edge: at_least <= (final sum >= thresh captured value). Reset value 0.
  - thresh=0 always yields at_least=1.
- When undefined: both ports and all related logic are absent; remaining behaviour is identical.

Test Plan:
- WIDTH=8, CHUNK=2, reset then start with data_in=8'h00, count_zeros=0 -> busy for 4 cycles; done pulses once 4 cycles after the accept edge; count=0.
- data_in=8'hFF -> count=8. data_in=8'hA5 -> count=4. data_in=8'h01 with count_zeros=1 -> count=7.
- start held high continuously with data_in alternating 8'h0F / 8'h81 -> done every 5 cycles; counts 4, 2, 4, 2; start pulses during COUNT (with data_in changes) do not alter results.
- Start 8'hFF, assert rst for 1 cycle at the second COUNT cycle -> busy=0, done never pulses, count=0. A following start with 8'h03 -> count=2.
- WIDTH=3, CHUNK=1, all 8 inputs 000..111 compared against the 3-input one-counter golden values (0,1,1,2,1,2,2,3) -> every count matches; done 3 cycles after each accept.
- POPCOUNT_THRESH_EN defined, WIDTH=8, thresh=5 -> data 8'h1F gives at_least=1; data 8'h0F gives at_least=0; thresh=0 with data 8'h00 gives at_least=1.
